spi_rx_deser: RTL and testbench

SPI slave receiver that sits directly downstream of the team's SPI master transmitter (mode 0, CPOL=0/CPHA=0, MSB first, active-low CS). It synchronizes the three SPI pins into the `clk` domain, shifts in one bit per SCLK rising edge, and presents each completed 16-bit word on a parallel valid/ready output port. It is the loopback and consumer stage for the transmitter on the same board-level `clk`.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_rx_deser.sv | 159 +++++++++++++++
 tb/tb_spi_rx_deser.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: word width, synchronizer depth, receiver state
// encoding and the bus mode constants (mode 0: CPOL=0, CPHA=0).
package spi_pkg;

  localparam int SPI_WORD_W      = 16;
  localparam int SPI_SYNC_STAGES = 2;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } spi_rx_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, followed by one
// extra flop so rising/falling edges of the synchronized level can be seen.
// RESET_VAL is the idle level of the pin, so no false edge appears after reset.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_STAGES-1:0] sync_r;
  logic                       edge_r;

  // Shift the pin through the synchronizer chain and keep the previous level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SPI_SYNC_STAGES{RESET_VAL}};
      edge_r <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[SPI_SYNC_STAGES-2:0], din};
      edge_r <= sync_r[SPI_SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SPI_SYNC_STAGES-1];
  assign rise  = level & ~edge_r;
  assign fall  = ~level & edge_r;

endmodule

// File: rtl/spi_rx_deser.sv
// SPI mode-0 slave receiver: synchronizes CS/SCLK/MOSI into clk, shifts one
// bit per SCLK rise (MSB first) and offers each full word on a single-entry
// valid/ready output register. A word that completes while the register is
// still full and not being consumed is dropped and flagged on `overrun`.
// Optional build macro SPI_RX_FRAME_CHECK_EN adds the `frame_err` port, which
// pulses on a short frame (CS released mid-word) or on extra SCLK rises.
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_WORD_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         spi_cs_l,
  input  logic                         spi_sclk,
  input  logic                         spi_data,
  output logic [DATA_W-1:0]            dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         overrun,
`ifdef SPI_RX_FRAME_CHECK_EN
  output logic                         frame_err,
`endif
  output logic [$clog2(DATA_W+1)-1:0]  bit_count
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  spi_rx_state_e     state_r;
  logic [DATA_W-1:0] shift_r;

  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic data_s, data_rise_s, data_fall_s;
  logic unused_edges_s;

  logic [DATA_W-1:0] next_word_s;
  logic              word_done_s;
  logic              load_ok_s;

  // CS idles high, so its synchronizer resets to 1 to avoid a false cs_fall
  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi_cs_l),
    .level (cs_level_s),
    .rise  (cs_rise_s),
    .fall  (cs_fall_s)
  );

  spi_sync_edge #(.RESET_VAL(SPI_CPOL)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi_sclk),
    .level (sclk_level_s),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  // MOSI only needs its synchronized level; its edge outputs are not used
  spi_sync_edge #(.RESET_VAL(1'b0)) u_data_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi_data),
    .level (data_s),
    .rise  (data_rise_s),
    .fall  (data_fall_s)
  );

  assign unused_edges_s = ^{cs_rise_s, sclk_level_s, sclk_fall_s, data_rise_s, data_fall_s};

  // Decode the cycle on which the last bit of a word arrives and whether the output register can take it
  always_comb begin
    next_word_s = {shift_r[DATA_W-2:0], data_s};
    word_done_s = 1'b0;
    if ((state_r == SHIFT) && !cs_level_s && sclk_rise_s && (bit_count == LAST_CNT)) begin
      word_done_s = 1'b1;
    end else begin
      word_done_s = 1'b0;
    end
    load_ok_s = !dout_valid || dout_ready;
  end

  // Receiver FSM, shift register, bit counter and the single-entry output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      shift_r    <= {DATA_W{1'b0}};
      bit_count  <= {CNT_W{1'b0}};
      dout       <= {DATA_W{1'b0}};
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SPI_RX_FRAME_CHECK_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
`ifdef SPI_RX_FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          bit_count <= {CNT_W{1'b0}};
          if (cs_fall_s) begin
            state_r <= SHIFT;
            shift_r <= {DATA_W{1'b0}};
          end
        end
        SHIFT: begin
          if (cs_level_s) begin
            // CS released before the word completed: drop the partial frame
            state_r   <= IDLE;
            bit_count <= {CNT_W{1'b0}};
`ifdef SPI_RX_FRAME_CHECK_EN
            if (bit_count != {CNT_W{1'b0}}) begin
              frame_err <= 1'b1;
            end
`endif
          end else if (sclk_rise_s) begin
            shift_r   <= next_word_s;
            bit_count <= bit_count + CNT_W'(1);
            if (bit_count == LAST_CNT) begin
              state_r <= WAIT_CS;
            end
          end
        end
        WAIT_CS: begin
          // Extra SCLK rises past a full word are ignored
          if (cs_level_s) begin
            state_r   <= IDLE;
            bit_count <= {CNT_W{1'b0}};
          end
`ifdef SPI_RX_FRAME_CHECK_EN
          if (sclk_rise_s) begin
            frame_err <= 1'b1;
          end
`endif
        end
        default: begin
          state_r   <= IDLE;
          bit_count <= {CNT_W{1'b0}};
        end
      endcase

      if (word_done_s) begin
        if (load_ok_s) begin
          dout       <= next_word_s;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_deser.sv
// Directed bench for spi_rx_deser. SPI pins are driven with the team
// transmitter timing: MOSI set one clk before SCLK rise, SCLK high 1 clk,
// low 2 clk, CS high 2 clk between frames. Outputs are sampled #1 after the
// rising edge; a negedge monitor accumulates pulse counts and flags.
module tb_spi_rx_deser;

  logic        clk;
  logic        reset;
  logic        spi_cs_l;
  logic        spi_sclk;
  logic        spi_data;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overrun;
  logic [4:0]  bit_count;
`ifdef SPI_RX_FRAME_CHECK_EN
  logic        frame_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // monitor accumulators
  int valid_cycles = 0;
  int accept_cnt   = 0;
  int overrun_cnt  = 0;
  int ferr_cnt     = 0;
  int bc_bad       = 0;
  int bc_max       = 0;
  int stab_bad     = 0;
  int          prev_bc    = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] prev_dout  = 16'h0000;

  spi_rx_deser dut (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_l   (spi_cs_l),
    .spi_sclk   (spi_sclk),
    .spi_data   (spi_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
`ifdef SPI_RX_FRAME_CHECK_EN
    .frame_err  (frame_err),
`endif
    .bit_count  (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses, handshakes and protocol-rule violations
  always @(negedge clk) begin
    if (!reset) begin
      if (dout_valid) valid_cycles++;
      if (dout_valid && dout_ready) accept_cnt++;
      if (overrun) overrun_cnt++;
`ifdef SPI_RX_FRAME_CHECK_EN
      if (frame_err) ferr_cnt++;
`endif
      if ((int'(bit_count) != prev_bc) && (int'(bit_count) != prev_bc + 1) && (bit_count != 5'd0)) bc_bad++;
      if (int'(bit_count) > 16) bc_bad++;
      if (int'(bit_count) > bc_max) bc_max = int'(bit_count);
      if (prev_valid && !prev_ready && (!dout_valid || (dout != prev_dout))) stab_bad++;
    end
    prev_bc    = int'(bit_count);
    prev_valid = dout_valid;
    prev_ready = dout_ready;
    prev_dout  = dout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Send the top n bits of w, MSB first; CS must already be low
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      spi_data = w[15-i];
      spi_sclk = 1'b0;
      tick();
      spi_sclk = 1'b1;
      tick();
      spi_sclk = 1'b0;
      tick();
    end
  endtask

  // Full CS-framed transfer; ready_pulse raises dout_ready only on the completing edge
  task automatic send_frame(input logic [15:0] w, input int n, input logic ready_pulse);
    spi_cs_l = 1'b0;
    tick();
    send_bits(w, n);
    if (ready_pulse) dout_ready = 1'b1;
    spi_cs_l = 1'b1;
    tick();
    if (ready_pulse) dout_ready = 1'b0;
    tick();
  endtask

  initial begin
    int acc0, val0, ovr0, ferr0;

    reset      = 1'b1;
    spi_cs_l   = 1'b1;
    spi_sclk   = 1'b0;
    spi_data   = 1'b0;
    dout_ready = 1'b1;
    idle(3);

    // reset state
    check("rst_dout",      32'(dout),       32'h0000);
    check("rst_valid",     32'(dout_valid), 32'h0);
    check("rst_overrun",   32'(overrun),    32'h0);
    check("rst_bit_count", 32'(bit_count),  32'h0);
    reset = 1'b0;
    idle(3);

    // two back-to-back A5C3 frames, consumer always ready
    acc0 = accept_cnt; ovr0 = overrun_cnt;
    send_frame(16'hA5C3, 16, 1'b0);
    send_frame(16'hA5C3, 16, 1'b0);
    idle(3);
    check("b2b_dout",      32'(dout), 32'hA5C3);
    check("b2b_accepts",   32'(accept_cnt - acc0), 32'd2);
    check("b2b_overrun",   32'(overrun_cnt - ovr0), 32'd0);
    check("b2b_bc_max",    32'(bc_max), 32'd16);
    check("b2b_bit_count", 32'(bit_count), 32'd0);

    // 8001 with ready tied high: valid for exactly one cycle
    val0 = valid_cycles;
    send_frame(16'h8001, 16, 1'b0);
    idle(3);
    check("r1_dout",         32'(dout), 32'h8001);
    check("r1_valid_cycles", 32'(valid_cycles - val0), 32'd1);

    // 1234 then FFFF with ready low: second word dropped
    dout_ready = 1'b0;
    ovr0 = overrun_cnt;
    send_frame(16'h1234, 16, 1'b0);
    send_frame(16'hFFFF, 16, 1'b0);
    idle(3);
    check("ovr_dout",    32'(dout), 32'h1234);
    check("ovr_valid",   32'(dout_valid), 32'h1);
    check("ovr_pulses",  32'(overrun_cnt - ovr0), 32'd1);
    dout_ready = 1'b1;
    tick();
    check("ovr_drain_valid", 32'(dout_valid), 32'h0);
    check("ovr_drain_dout",  32'(dout), 32'h1234);

    // CS released after 7 bits, then a full 00F0 frame
    acc0 = accept_cnt; ferr0 = ferr_cnt;
    spi_cs_l = 1'b0;
    tick();
    send_bits(16'hFE00, 7);
    tick();
    check("abort_bit_count", 32'(bit_count), 32'd7);
    spi_cs_l = 1'b1;
    idle(2);
    send_frame(16'h00F0, 16, 1'b0);
    idle(3);
    check("abort_dout",    32'(dout), 32'h00F0);
    check("abort_accepts", 32'(accept_cnt - acc0), 32'd1);
`ifdef SPI_RX_FRAME_CHECK_EN
    check("abort_frame_err", 32'(ferr_cnt - ferr0), 32'd1);
`else
    check("abort_no_ferr", 32'(ferr_cnt - ferr0), 32'd0);
`endif

    // reset after 9 bits of BEEF, then 0F0F
    spi_cs_l = 1'b0;
    tick();
    send_bits(16'hBEEF, 9);
    tick();
    check("mid_bit_count", 32'(bit_count), 32'd9);
    reset    = 1'b1;
    spi_cs_l = 1'b1;
    #1;
    check("mrst_dout",      32'(dout), 32'h0000);
    check("mrst_valid",     32'(dout_valid), 32'h0);
    check("mrst_bit_count", 32'(bit_count), 32'd0);
    tick();
    reset = 1'b0;
    idle(3);
    send_frame(16'h0F0F, 16, 1'b0);
    idle(3);
    check("post_rst_dout", 32'(dout), 32'h0F0F);

    // ready raised on the very cycle a new word completes
    dout_ready = 1'b0;
    ovr0 = overrun_cnt;
    send_frame(16'h1111, 16, 1'b0);
    idle(3);
    check("same_first_dout", 32'(dout), 32'h1111);
    acc0 = accept_cnt;
    send_frame(16'h2222, 16, 1'b1);
    idle(3);
    check("same_dout",    32'(dout), 32'h2222);
    check("same_valid",   32'(dout_valid), 32'h1);
    check("same_accepts", 32'(accept_cnt - acc0), 32'd1);
    check("same_overrun", 32'(overrun_cnt - ovr0), 32'd0);
    dout_ready = 1'b1;
    idle(2);

    check("bit_count_sequence", 32'(bc_bad), 32'd0);
    check("dout_stable",        32'(stab_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
